adc_peak_qualifier: RTL

Upstream stage of the max-value register in the tracking datapath. Accepts raw ADC samples and averages them over fixed windows of 2^LOG2_AVG samples. Compares each window average against the currently stored maximum (LV) with a hysteresis margin. Drives the single-cycle enable GT and the pending value PV that the register captures, plus a per-sweep window count.

---
 rtl/adc_peak_qualifier.sv | 119 +++++++++++
 1 files changed

// File: rtl/adc_peak_qualifier.sv
// Window-averaging peak qualifier: averages 2^LOG2_AVG ADC samples per window and
// flags a new maximum (GT) when the average exceeds the stored maximum LV by HYST.
module adc_peak_qualifier #(
    parameter int ADC_W    = 12,
    parameter int LOG2_AVG = 2,
    parameter int HYST     = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    input  logic [ADC_W-1:0] LV,
    input  logic             SWEEP_START,
    output logic [ADC_W-1:0] PV,
    output logic             GT,
    output logic             AVG_VALID,
    output logic [15:0]      WIN_CNT
);

    localparam int ACC_W = ADC_W + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int N     = 1 << LOG2_AVG;

    typedef enum logic {
        ST_ACC,
        ST_CMP
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               first, first_nxt;
    logic [ADC_W-1:0]   pv_nxt;
    logic               gt_nxt, avg_valid_nxt;
    logic [15:0]        win_cnt_nxt;

    logic [ADC_W-1:0]   avg;
    logic [ADC_W:0]     thr;

    assign avg = ADC_W'(acc >> LOG2_AVG);
    // One extra bit so LV near full scale cannot wrap the threshold down.
    assign thr = {1'b0, LV} + (ADC_W+1)'(HYST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        first_nxt     = first;
        pv_nxt        = PV;
        gt_nxt        = 1'b0;
        avg_valid_nxt = 1'b0;
        win_cnt_nxt   = WIN_CNT;

        if (SWEEP_START) begin
            acc_nxt     = '0;
            cnt_nxt     = '0;
            win_cnt_nxt = '0;
            first_nxt   = 1'b1;
            state_nxt   = ST_ACC;
        end else begin
            unique case (state)
                ST_ACC: begin
                    if (ADC_VALID) begin
                        acc_nxt = acc + ACC_W'(ADC_DATA);
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_CMP: begin
                    pv_nxt        = avg;
                    avg_valid_nxt = 1'b1;
                    gt_nxt        = first | ({1'b0, avg} > thr);
                    first_nxt     = 1'b0;
                    if (WIN_CNT != 16'hFFFF)
                        win_cnt_nxt = WIN_CNT + 16'd1;
                    // A sample arriving during compare opens the next window.
                    if (ADC_VALID) begin
                        acc_nxt = ACC_W'(ADC_DATA);
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        acc_nxt = '0;
                        cnt_nxt = '0;
                    end
                end
                default: state_nxt = ST_ACC;
            endcase
            state_nxt = (cnt_nxt == CNT_W'(N)) ? ST_CMP : ST_ACC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc       <= '0;
            cnt       <= '0;
            first     <= 1'b1;
            PV        <= '0;
            GT        <= 1'b0;
            AVG_VALID <= 1'b0;
            WIN_CNT   <= '0;
        end else begin
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            first     <= first_nxt;
            PV        <= pv_nxt;
            GT        <= gt_nxt;
            AVG_VALID <= avg_valid_nxt;
            WIN_CNT   <= win_cnt_nxt;
        end
    end

endmodule
